// File: rtl/bcd_calc_pkg.sv
// Shared types and constants for the serial BCD add/subtract datapath.
package bcd_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit_slice.sv
// Single-digit BCD add/subtract slice: nines-complement select, binary add, +6 correction.
// Purely combinational; no handshake.
module bcd_digit_slice
  import bcd_calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   sub,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   cout
);

  logic [BCD_DIGIT_W-1:0] b_sel;
  logic [BCD_DIGIT_W:0]   sum;

  always_comb begin
    b_sel = sub ? (BCD_NINE - b) : b;
    sum   = {1'b0, a} + {1'b0, b_sel} + {{BCD_DIGIT_W{1'b0}}, cin};
    if (sum > 5'd9) begin
      digit = sum[BCD_DIGIT_W-1:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = sum[BCD_DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu_ctrl.sv
// Serial BCD add/subtract controller: one shared digit slice, LSD first; BCD_INVALID_CHECK_EN adds operand validation.
// Latency: accept edge + NDIGITS run edges, then a one-cycle done pulse (invalid operands: done right after accept).
// Backpressure: start is honoured only while ready; requests during busy are dropped, not queued.
module bcd_serial_alu_ctrl
  import bcd_calc_pkg::*;
#(
  parameter int NDIGITS = 2
) (
  input  logic                       CLOCK_50,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       op,
  input  logic [4*NDIGITS-1:0]       a_bcd,
  input  logic [4*NDIGITS-1:0]       b_bcd,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [4*NDIGITS-1:0]       result,
  output logic                       flag,
  output logic                       invalid
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 state, state_nxt;
  logic [4*NDIGITS-1:0]   a_q, b_q, result_q;
  logic                   op_q, carry, flag_q;
  logic [IDX_W-1:0]       idx;
  logic [BCD_DIGIT_W-1:0] a_dig, b_dig, slice_digit;
  logic                   slice_cout, run_flag, last, nib_bad;

  assign last     = (idx == IDX_W'(NDIGITS - 1));
  assign run_flag = (op_q == OP_ADD) ? slice_cout : ~slice_cout;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        b_dig = b_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  bcd_digit_slice u_slice (
    .a     (a_dig),
    .b     (b_dig),
    .sub   (op_q),
    .cin   (carry),
    .digit (slice_digit),
    .cout  (slice_cout)
  );

`ifdef BCD_INVALID_CHECK_EN
  logic invalid_q;

  always_comb begin
    nib_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if ((a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_NINE) ||
          (b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_NINE))
        nib_bad = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst)
      invalid_q <= 1'b0;
    else if (state == IDLE && start)
      invalid_q <= nib_bad;
  end

  assign invalid = invalid_q;
`else
  assign nib_bad = 1'b0;
  assign invalid = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start)
          state_nxt = nib_bad ? DONE : RUN;
      end
      RUN: begin
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a_bcd;
            b_q      <= b_bcd;
            op_q     <= op;
            idx      <= '0;
            carry    <= op;
            result_q <= '0;
            flag_q   <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IDX_W'(i))
              result_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= slice_digit;
          end
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          // Out-of-range results are reported as zero plus the flag.
          if (last) begin
            flag_q <= run_flag;
            if (run_flag)
              result_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flag   = flag_q;

endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Bench for bcd_serial_alu_ctrl: directed and random operations checked against an integer-arithmetic model.
module tb_bcd_serial_alu_ctrl;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_bcd = '0;
  logic [W-1:0] b_bcd = '0;
  logic         ready, busy, done, flag, invalid;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_serial_alu_ctrl #(.NDIGITS(N)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag     (flag),
    .invalid  (invalid)
  );

  function automatic int bcd2int(input logic [W-1:0] v);
    int s = 0;
    int m = 1;
    for (int i = 0; i < N; i++) begin
      s += int'(v[i*4 +: 4]) * m;
      m *= 10;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                                output logic [W-1:0] r, output logic f);
    int av = bcd2int(a);
    int bv = bcd2int(b);
    int s;
    if (!o) begin
      s = av + bv;
      f = (s >= 10 ** N);
    end else begin
      s = av - bv;
      f = (av < bv);
    end
    r = f ? '0 : int2bcd(s);
  endfunction

  // Issue one operation from IDLE; lat counts negedges after the accept edge until done (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                        output logic [W-1:0] res, output logic flg, output logic inv, output int lat);
    @(negedge clk);
    start = 1'b1; a_bcd = a; b_bcd = b; op = o;
    @(negedge clk);
    start = 1'b0; a_bcd = W'($urandom); b_bcd = W'($urandom); op = ~o;
    lat = -1; res = 'x; flg = 1'bx; inv = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k; res = result; flg = flag; inv = invalid;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int saw_done;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got %h want 00", result); end
    tests++; if (flag !== 1'b0) begin fails++; $display("FAIL reset_flag got %b want 0", flag); end
    tests++; if (invalid !== 1'b0) begin fails++; $display("FAIL reset_invalid got %b want 0", invalid); end
    start = 1'b1; a_bcd = 8'h45; b_bcd = 8'h38; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    tests++; if (ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_idle got ready=%b busy=%b want ready=1 busy=0", ready, busy);
    end
    tests++; if (result !== '0) begin fails++; $display("FAIL midrst_result got %h want 00", result); end
    saw_done = 0;
    repeat (2) begin @(negedge clk); if (done) saw_done++; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (done) saw_done++; end
    tests++; if (saw_done != 0) begin fails++; $display("FAIL midrst_no_done got %0d pulses want 0", saw_done); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{8'h45, 8'h09, 8'h99, 8'h50, 8'h50, 8'h07, 8'h23, 8'h00};
    logic [W-1:0] tb [8] = '{8'h38, 8'h01, 8'h01, 8'h50, 8'h23, 8'h07, 8'h50, 8'h00};
    logic         to [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [W-1:0] er [8] = '{8'h83, 8'h10, 8'h00, 8'h00, 8'h27, 8'h00, 8'h00, 8'h00};
    logic         ef [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic [W-1:0] res;
    logic flg, inv;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], to[i], res, flg, inv, lat);
      tests++; if (lat != N) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N); end
      tests++; if (res !== er[i]) begin fails++; $display("FAIL dir%0d_result %h op%b %h got %h want %h", i, ta[i], to[i], tb[i], res, er[i]); end
      tests++; if (flg !== ef[i]) begin fails++; $display("FAIL dir%0d_flag got %b want %b", i, flg, ef[i]); end
      tests++; if (inv !== 1'b0) begin fails++; $display("FAIL dir%0d_invalid got %b want 0", i, inv); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, exp_r;
    logic o, flg, inv, exp_f;
    int lat;
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < N; d++) begin
        a[d*4 +: 4] = 4'($urandom_range(0, 9));
        b[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      o = 1'($urandom);
      model(a, b, o, exp_r, exp_f);
      run_op(a, b, o, res, flg, inv, lat);
      tests++; if (lat != N) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, N); end
      tests++; if (res !== exp_r) begin fails++; $display("FAIL rnd%0d_result %h op%b %h got %h want %h", i, a, o, b, res, exp_r); end
      tests++; if (flg !== exp_f) begin fails++; $display("FAIL rnd%0d_flag got %b want %b", i, flg, exp_f); end
      tests++; if (inv !== 1'b0) begin fails++; $display("FAIL rnd%0d_invalid got %b want 0", i, inv); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    logic [W-1:0] res;
    logic flg;
    @(negedge clk);
    start = 1'b1; a_bcd = 8'h12; b_bcd = 8'h34; op = 1'b0;
    @(negedge clk);
    a_bcd = 8'h77; b_bcd = 8'h11; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; res = 'x; flg = 1'bx;
    for (int k = 1; k < 20; k++) begin
      if (done) begin lat = k; res = result; flg = flag; break; end
      @(negedge clk);
    end
    tests++; if (lat != N) begin fails++; $display("FAIL busy_latency got %0d want %0d", lat, N); end
    tests++; if (res !== 8'h46 || flg !== 1'b0) begin
      fails++; $display("FAIL busy_result got %h flag %b want 46 flag 0", res, flg);
    end
    extra = 0;
    repeat (6) begin @(negedge clk); if (done || busy) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL busy_no_queue got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cnt, prev, bad_gap, bad_res, first;
    @(negedge clk);
    start = 1'b1; a_bcd = 8'h12; b_bcd = 8'h34; op = 1'b0;
    cnt = 0; prev = -1; bad_gap = 0; bad_res = 0; first = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = c;
        if (prev >= 0 && c - prev != 4) bad_gap++;
        if (result !== 8'h46 || flag !== 1'b0) bad_res++;
        prev = c;
        cnt++;
      end
    end
    start = 1'b0;
    tests++; if (first != N) begin fails++; $display("FAIL b2b_first_done got %0d want %0d", first, N); end
    tests++; if (cnt != 4) begin fails++; $display("FAIL b2b_count got %0d want 4", cnt); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL b2b_period got %0d bad gaps want 0", bad_gap); end
    tests++; if (bad_res != 0) begin fails++; $display("FAIL b2b_result got %0d wrong results want 0", bad_res); end
    for (int k = 0; k < 10 && !ready; k++) @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got ready=%b want 1", ready); end
  endtask

`ifdef BCD_INVALID_CHECK_EN
  task automatic test_invalid();
    logic [W-1:0] res;
    logic flg, inv;
    int lat;
    run_op(8'h3A, 8'h01, 1'b0, res, flg, inv, lat);
    tests++; if (lat != 0) begin fails++; $display("FAIL inv_latency got %0d want 0", lat); end
    tests++; if (inv !== 1'b1) begin fails++; $display("FAIL inv_flagged got %b want 1", inv); end
    tests++; if (res !== '0 || flg !== 1'b0) begin fails++; $display("FAIL inv_result got %h flag %b want 00 flag 0", res, flg); end
    @(negedge clk);
    tests++; if (invalid !== 1'b1) begin fails++; $display("FAIL inv_hold got %b want 1", invalid); end
    run_op(8'h12, 8'h01, 1'b0, res, flg, inv, lat);
    tests++; if (lat != N) begin fails++; $display("FAIL inv_next_latency got %0d want %0d", lat, N); end
    tests++; if (inv !== 1'b0 || res !== 8'h13 || flg !== 1'b0) begin
      fails++; $display("FAIL inv_next got inv=%b res=%h flag=%b want inv=0 res=13 flag=0", inv, res, flg);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
`ifdef BCD_INVALID_CHECK_EN
    test_invalid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
